// File: rtl/inst_rom_ctrl_if.sv
// Fetch-port and byte-loader bundle for inst_rom_ctrl.
// master: core/loader side.  slave: the instruction ROM.
// ld_csum exists only when INST_ROM_CHECKSUM_EN is defined.
interface inst_rom_ctrl_if #(
  parameter int DEPTH_LOG2 = 10
);
  logic                  ce;
  logic [31:0]           addr;
  logic [31:0]           inst;
  logic                  ld_start;
  logic                  ld_valid;
  logic [7:0]            ld_byte;
  logic                  ld_ready;
  logic                  ld_end;
  logic                  ld_busy;
  logic                  ld_done;
  logic                  ld_err;
  logic [DEPTH_LOG2:0]   ld_words;
`ifdef INST_ROM_CHECKSUM_EN
  logic [31:0]           ld_csum;

  modport master (
    output ce, addr, ld_start, ld_valid, ld_byte, ld_end,
    input  inst, ld_ready, ld_busy, ld_done, ld_err, ld_words, ld_csum
  );
  modport slave (
    input  ce, addr, ld_start, ld_valid, ld_byte, ld_end,
    output inst, ld_ready, ld_busy, ld_done, ld_err, ld_words, ld_csum
  );
`else
  modport master (
    output ce, addr, ld_start, ld_valid, ld_byte, ld_end,
    input  inst, ld_ready, ld_busy, ld_done, ld_err, ld_words
  );
  modport slave (
    input  ce, addr, ld_start, ld_valid, ld_byte, ld_end,
    output inst, ld_ready, ld_busy, ld_done, ld_err, ld_words
  );
`endif
endinterface

// File: rtl/inst_rom_ctrl.sv
// Instruction ROM with a byte-serial program loader.
// Fetch is combinational; while a load is in progress fetches see NOP_INST.
// Optional feature macro: INST_ROM_CHECKSUM_EN adds ld_csum (sum of written words).
//
// Loader handshake: a byte transfers on a rising edge where ld_valid and
// ld_ready are both 1. ld_ready is 1 in LOAD while the array is not full.
// ld_start and ld_end are single-cycle pulses and take priority over a byte
// presented in the same cycle (that byte is dropped, not transferred).
//
// dbg_state_o encoding: 0 = IDLE, 1 = LOAD, 2 = FLUSH.
module inst_rom_ctrl #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic           clk,
  input  logic           rst_n,
  inst_rom_ctrl_if.slave bus,
  output logic [1:0]     dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  localparam logic [DEPTH_LOG2:0] DEPTH_W = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [31:0]           mem_q [0:(1 << DEPTH_LOG2) - 1];

  state_e                state_q, state_d;
  logic [DEPTH_LOG2:0]   wptr_q, wptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [23:0]           buf_q, buf_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic [DEPTH_LOG2:0]   words_q, words_d;
  logic [31:0]           csum_q, csum_d;

  logic                  full;
  logic                  ready;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic [31:0]           mem_wdata;
  logic                  unused_addr_lsb;

  assign full            = (wptr_q == DEPTH_W);
  assign unused_addr_lsb = ^bus.addr[1:0];

  // Zero-latency fetch path: disabled -> 0, loading or out of range -> NOP.
  always_comb begin
    bus.inst = 32'h0;
    if (bus.ce) begin
      if (state_q != S_IDLE || |bus.addr[31:DEPTH_LOG2+2]) bus.inst = NOP_INST;
      else                                                  bus.inst = mem_q[bus.addr[DEPTH_LOG2+1:2]];
    end
  end

  // Loader next-state, register updates and memory write request.
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    err_d     = err_q;
    done_d    = done_q;
    words_d   = words_q;
    csum_d    = csum_q;
    ready     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wptr_q[DEPTH_LOG2-1:0];
    mem_wdata = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (bus.ld_start) begin
          state_d = S_LOAD;
          wptr_d  = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          done_d  = 1'b0;
          words_d = '0;
          csum_d  = '0;
        end
      end
      S_LOAD: begin
        ready = !full;
        if (bus.ld_start) begin
          wptr_d  = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          done_d  = 1'b0;
          words_d = '0;
          csum_d  = '0;
        end else if (bus.ld_end) begin
          if (cnt_q != 2'd0) begin
            state_d = S_FLUSH;
          end else begin
            state_d = S_IDLE;
            done_d  = !err_q;
            words_d = wptr_q;
          end
        end else if (bus.ld_valid) begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            case (cnt_q)
              2'd0: buf_d[7:0]   = bus.ld_byte;
              2'd1: buf_d[15:8]  = bus.ld_byte;
              2'd2: buf_d[23:16] = bus.ld_byte;
              default: begin
                mem_we    = 1'b1;
                mem_wdata = {bus.ld_byte, buf_q};
                wptr_d    = wptr_q + 1'b1;
              end
            endcase
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      S_FLUSH: begin
        state_d = S_IDLE;
        if (full) begin
          err_d   = 1'b1;
          done_d  = 1'b0;
          words_d = wptr_q;
        end else begin
          mem_we = 1'b1;
          case (cnt_q)
            2'd1:    mem_wdata = {24'h0, buf_q[7:0]};
            2'd2:    mem_wdata = {16'h0, buf_q[15:0]};
            default: mem_wdata = {8'h0, buf_q};
          endcase
          wptr_d  = wptr_q + 1'b1;
          done_d  = !err_q;
          words_d = wptr_q + 1'b1;
        end
        cnt_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
    if (mem_we) csum_d = csum_d + mem_wdata;
  end

  // Loader state and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      words_q <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
      done_q  <= done_d;
      words_q <= words_d;
      csum_q  <= csum_d;
    end
  end

  // Word array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.ld_ready  = ready;
  assign bus.ld_busy   = (state_q != S_IDLE);
  assign bus.ld_done   = done_q;
  assign bus.ld_err    = err_q;
  assign bus.ld_words  = words_q;
  assign dbg_state_o   = state_q;
`ifdef INST_ROM_CHECKSUM_EN
  assign bus.ld_csum   = csum_q;
`else
  logic [31:0] unused_csum;
  assign unused_csum = csum_q;
`endif

endmodule
